key_validator: RTL

KEY_VALIDATOR -- requirements
Module: key_validator

---
 rtl/key_validator.sv | 106 ++++++++++
 1 files changed

// File: rtl/key_validator.sv
// key_validator: keypad code checker with consecutive-failure lockout.
module key_validator #(
   parameter int DIGIT_W     = 4,
   parameter int DIGITS      = 4,
   parameter int MAX_FAILS   = 3,
   parameter int LOCK_CYCLES = 1000,
   localparam int KEY_W = DIGIT_W * DIGITS,
   localparam int FW    = $clog2(MAX_FAILS + 1),
   localparam int CW    = $clog2(DIGITS + 1),
   localparam int TW    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [DIGIT_W-1:0] digit_in_i,
   input  logic               digit_valid_i,
   input  logic               enter_i,
   input  logic               clear_i,
   input  logic [KEY_W-1:0]   set_key_i,
   output logic               correct_signal_o,
   output logic               wrong_signal_o,
   output logic               locked_o,
   output logic [FW-1:0]      fail_count_o,
   output logic [CW-1:0]      digit_count_o
);
   typedef enum logic {IDLE, LOCKED} state_t;
   state_t             state_q, state_d;
   logic [KEY_W-1:0]   buf_q, buf_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [FW-1:0]      fails_q, fails_d;
   logic [TW-1:0]      timer_q, timer_d;
   logic               correct_q, correct_d;
   logic               wrong_q, wrong_d;
   logic               locked_q, locked_d;
   logic               full, match;
   logic [FW-1:0]      fails_inc;
   assign full      = cnt_q == CW'(DIGITS);
   assign match     = full && buf_q == set_key_i;
   assign fails_inc = fails_q + 1'b1;
   always_comb begin
      state_d   = state_q;
      buf_d     = buf_q;
      cnt_d     = cnt_q;
      fails_d   = fails_q;
      timer_d   = timer_q;
      correct_d = correct_q;
      wrong_d   = 1'b0;
      locked_d  = locked_q;
      if (state_q == IDLE) begin
         if (clear_i) begin
            buf_d     = '0;
            cnt_d     = '0;
            correct_d = 1'b0;
         end else if (enter_i) begin
            buf_d     = '0;
            cnt_d     = '0;
            correct_d = match;
            wrong_d   = !match;
            fails_d   = match ? '0 : fails_inc;
            // Lockout begins in the same cycle as the failing pulse
            if (!match && fails_inc == FW'(MAX_FAILS)) begin
               state_d  = LOCKED;
               locked_d = 1'b1;
               timer_d  = TW'(LOCK_CYCLES - 1);
            end
         end else if (digit_valid_i && !full) begin
            buf_d     = (buf_q << DIGIT_W) | KEY_W'(digit_in_i);
            cnt_d     = cnt_q + 1'b1;
            correct_d = 1'b0;
         end
      end else if (timer_q == '0) begin
         state_d  = IDLE;
         locked_d = 1'b0;
         fails_d  = '0;
         buf_d    = '0;
         cnt_d    = '0;
      end else begin
         timer_d = timer_q - 1'b1;
      end
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         buf_q     <= '0;
         cnt_q     <= '0;
         fails_q   <= '0;
         timer_q   <= '0;
         correct_q <= 1'b0;
         wrong_q   <= 1'b0;
         locked_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         buf_q     <= buf_d;
         cnt_q     <= cnt_d;
         fails_q   <= fails_d;
         timer_q   <= timer_d;
         correct_q <= correct_d;
         wrong_q   <= wrong_d;
         locked_q  <= locked_d;
      end
   end
   assign correct_signal_o = correct_q;
   assign wrong_signal_o   = wrong_q;
   assign locked_o         = locked_q;
   assign fail_count_o     = fails_q;
   assign digit_count_o    = cnt_q;
endmodule
